// File: rtl/ffo_pkg.sv
// rtl/ffo_pkg.sv - shared defaults, index-width helper and iterator state type
package ffo_pkg;

    localparam int N_DEFAULT = 64;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ffo_lsb.sv
// rtl/ffo_lsb.sv - combinational find-first-one from the least significant bit
module ffo_lsb
    import ffo_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0]              vec,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      found
);

    localparam int IDXW = idx_width(N);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    assign found = |vec;

endmodule

// File: rtl/set_bit_iterator.sv
// rtl/set_bit_iterator.sv - streams the index of every set bit of an accepted mask, lowest first
module set_bit_iterator
    import ffo_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [idx_width(N)-1:0]   out_idx,
    output logic [idx_width(N)-1:0]   out_seq,
    output logic                      out_last,
    output logic                      zero_drop
);

    localparam int IDXW = idx_width(N);

    state_t          state_q, state_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [IDXW-1:0] seq_q, seq_d;
    logic            rdy_q, rdy_d;
    logic            zero_q, zero_d;

    logic [N-1:0]    mask_rest;
    logic            ffo_found;
    logic            run;

    ffo_lsb #(.N(N)) u_ffo (
        .vec   (mask_q),
        .idx   (out_idx),
        .found (ffo_found)
    );

    // Dropping the lowest set bit is the same as clearing bit out_idx.
    assign mask_rest = mask_q & (mask_q - N'(1));
    assign run       = (state_q == RUN);

    assign out_valid = run;
    assign out_seq   = seq_q;
    assign out_last  = run && (mask_rest == '0);
    assign in_ready  = rdy_q;
    assign zero_drop = zero_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            mask_q  <= '0;
            seq_q   <= '0;
            rdy_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            seq_q   <= seq_d;
            rdy_q   <= rdy_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        seq_d   = seq_q;
        rdy_d   = rdy_q;
        zero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (in_valid && rdy_q) begin
                    if (in_data == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        mask_d  = in_data;
                        seq_d   = '0;
                        rdy_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rdy_d = 1'b0;
                if (out_ready && ffo_found) begin
                    mask_d = mask_rest;
                    // Return seq to 0 on the last beat so it never wraps.
                    if (out_last) begin
                        seq_d   = '0;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        seq_d = seq_q + IDXW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// tb/tb_set_bit_iterator.sv - directed self-checking bench for set_bit_iterator
module tb_set_bit_iterator;

    logic        clk;
    logic        rstb;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic [5:0]  out_seq;
    logic        out_last;
    logic        zero_drop;

    int total = 0;
    int bad   = 0;

    set_bit_iterator #(.N(64)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_seq   (out_seq),
        .out_last  (out_last),
        .zero_drop (zero_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int idx, input int seq, input logic last);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".idx"},   64'(out_idx),   64'(idx));
        chk({tag, ".seq"},   64'(out_seq),   64'(seq));
        chk({tag, ".last"},  64'(out_last),  64'(last));
        chk({tag, ".rdy"},   64'(in_ready),  64'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".idx"},   64'(out_idx),   64'd0);
        chk({tag, ".seq"},   64'(out_seq),   64'd0);
        chk({tag, ".last"},  64'(out_last),  64'd0);
        chk({tag, ".zd"},    64'(zero_drop), 64'd0);
    endtask

    initial begin
        rstb      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // reset values
        for (int i = 0; i < 10; i++) step();
        chk_quiet("rst");
        chk("rst.rdy", 64'(in_ready), 64'd0);
        rstb = 1'b1;
        step();
        chk("rel.rdy", 64'(in_ready), 64'd1);
        chk_quiet("rel");

        // mixed vector
        in_data   = 64'h8000_0000_0000_0011;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("mix0", 0, 0, 1'b0);
        step();
        chk_beat("mix1", 4, 1, 1'b0);
        step();
        chk_beat("mix2", 63, 2, 1'b1);
        step();
        chk("mix.done", 64'(out_valid), 64'd0);
        chk("mix.rdy",  64'(in_ready),  64'd1);

        // backpressure
        in_data   = 64'h6;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk_beat("bp.s0", 1, 0, 1'b0);
        step();
        chk_beat("bp.s1", 1, 0, 1'b0);
        step();
        chk_beat("bp.s2", 1, 0, 1'b0);
        out_ready = 1'b1;
        step();
        chk_beat("bp.b1", 2, 1, 1'b1);
        step();
        chk("bp.done", 64'(out_valid), 64'd0);
        chk("bp.rdy",  64'(in_ready),  64'd1);

        // zero vector
        in_data  = 64'h0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("zero.zd",    64'(zero_drop), 64'd1);
        chk("zero.valid", 64'(out_valid), 64'd0);
        chk("zero.rdy",   64'(in_ready),  64'd1);
        step();
        chk("zero.zd2",   64'(zero_drop), 64'd0);
        chk("zero.valid2", 64'(out_valid), 64'd0);
        chk("zero.rdy2",  64'(in_ready),  64'd1);

        // full vector
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk_beat($sformatf("full%0d", i), i, i, (i == 63));
            step();
        end
        chk("full.done", 64'(out_valid), 64'd0);
        chk("full.rdy",  64'(in_ready),  64'd1);

        // reset mid-run
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("mr0", 0, 0, 1'b0);
        step();
        chk_beat("mr1", 1, 1, 1'b0);
        step();
        chk_beat("mr2", 2, 2, 1'b0);
        #2;
        rstb = 1'b0;
        #1;
        chk_quiet("mr.rst");
        chk("mr.rst.rdy", 64'(in_ready), 64'd0);
        step();
        step();
        rstb = 1'b1;
        step();
        chk("mr.rel.rdy", 64'(in_ready), 64'd1);
        in_data  = 64'h1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("one", 0, 0, 1'b1);
        step();
        chk("one.done", 64'(out_valid), 64'd0);
        chk("one.rdy",  64'(in_ready),  64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_bit_iterator.md
# set_bit_iterator

Sequential enumerator that accepts an N-bit vector over a valid/ready handshake and emits the index of every set bit, lowest first, one index per cycle. It sits directly upstream of the find-first-one datapath and reuses that function internally. It serialises a captured bit mask into a stream of bit positions for downstream consumers such as grant, scheduling or free-list logic.

## Interface
- N, default 64, input vector width; N ≥ 2.
- IDXW, default $clog2(N), width of index outputs; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rstb  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a vector; registered.
- in_data  in  N  bit mask to enumerate.
- out_valid  out  1  out_idx/out_seq/out_last are valid.
- out_ready  in  1  downstream accepts the current beat.
- out_idx  out  IDXW  position of the lowest remaining set bit.
- out_seq  out  IDXW  ordinal of this beat within the vector, starting at 0.
- out_last  out  1  this beat is the final set bit of the vector.
- zero_drop  out  1  one-cycle pulse: an all-zero vector was accepted and discarded.

## Operation
- State machine has two states, IDLE and RUN.
- Internal registers:
  - mask_q[N-1:0]: remaining bits.
  - seq_q[IDXW-1:0]: beat counter.
  - rdy_q: drives in_ready.
- IDLE:
  - rdy_q=1 (from the first edge after reset release).
  - Accept when in_valid && in_ready.
  - If in_data==0: pulse zero_drop for 1 cycle, stay IDLE, rdy_q stays 1.
  - If in_data≠0: mask_q←in_data, seq_q←0, rdy_q←0, go to RUN.
- RUN:
  - out_valid=1.
  - out_idx = ffo(mask_q).
  - out_seq = seq_q.
  - out_last = ((mask_q & (mask_q−1)) == 0).
  - in_ready=0; no overlap between vectors.
- Output handshake (out_valid && out_ready):
  - Clear bit out_idx in mask_q; seq_q←seq_q+1.
  - If out_last: go to IDLE, rdy_q←1.
- Stall (out_valid && !out_ready): mask_q, seq_q and all outputs hold stable.
- in_valid during RUN is ignored; the upstream source must hold it until in_ready.
- out_idx, out_seq and out_last are combinational from mask_q/seq_q. All other outputs are registered or state-decoded.
- seq_q never wraps: the maximum value N−1 is reached only on the beat where out_last=1.

## Timing
- Reset (rstb=0) applies asynchronously:
  - State=IDLE, mask_q=0, seq_q=0, rdy_q=0.
  - out_valid=0, out_idx=0, out_seq=0, out_last=0, in_ready=0, zero_drop=0.
- Reset release: in_ready rises at the first rising edge with rstb=1.
- Latency: vector accepted at edge k → out_valid=1 with the first index after edge k.
- Throughput: 1 index per cycle with out_ready held high.
- A vector with P set bits occupies P cycles in RUN. in_ready returns 1 one cycle after the last handshake.
- Minimum vector-to-vector spacing is P+1 cycles.
- zero_drop is high for exactly the cycle after the accepting edge.
- Reset mid-RUN:
  - Outputs clear immediately, without waiting for a clock edge.
  - The partial vector is lost.
  - No out_last is emitted for it.

## Structure
- Package ffo_pkg holds:
  - the default N;
  - an index-width helper function;
  - the state enum typedef (IDLE, RUN).
- Sub-module ffo_lsb:
  - Parameterised by N; purely combinational.
  - Inputs: vec[N-1:0].
  - Outputs: idx[IDXW-1:0] of the lowest set bit, and found.
  - idx=0 when vec==0.
- set_bit_iterator instantiates one ffo_lsb on mask_q. The FSM, counters and handshake logic live in the top module.

## Test plan
- Reset values:
  - Stimulus: hold rstb=0 for 10 cycles.
  - Response: all outputs 0. in_ready=1 at the first edge after release. Asserting rstb mid-cycle clears the outputs before the next edge.
- Mixed vector:
  - Stimulus: in_data=64'h8000_0000_0000_0011, out_ready=1.
  - Response: out_idx = 0, 4, 63 on consecutive cycles; out_seq = 0, 1, 2; out_last only with idx 63; in_ready=1 on the following cycle.
- Backpressure:
  - Stimulus: in_data=64'h6, out_ready=0 for 3 cycles, then 1.
  - Response: out_idx=1, out_seq=0, out_last=0 stay stable for all 3 stall cycles; then out_idx=2 with out_last=1.
- Zero vector:
  - Stimulus: in_data=0 accepted.
  - Response: zero_drop=1 for exactly 1 cycle, out_valid stays 0, in_ready stays 1.
- Full vector:
  - Stimulus: in_data=64'hFFFF_FFFF_FFFF_FFFF.
  - Response: 64 beats with out_idx = 0..63; out_seq equals out_idx; out_last only on beat 63.
- Reset mid-run:
  - Stimulus: all-ones vector; assert rstb after 2 handshakes; release it, then send in_data=64'h1.
  - Response: outputs clear immediately on reset. The new vector yields a single beat: out_idx=0, out_seq=0, out_last=1.
